// File: rtl/mko_lbus_seq.sv
`timescale 1ns/1ps
// Local-bus access sequencer: turns Wishbone-classic single accesses into the
// ack_access_str / ack_access_reg_3 handshake consumed by the MKO register block.
module mko_lbus_seq #(
    parameter int         WB_DATA_WIDTH = 16,
    parameter int         WB_ADDR_WIDTH = 16,
    parameter logic [2:0] MKO_INT_REG   = 3'b101,
    parameter int         MIN_ACC_CYC   = 8,
    parameter int         TIMEOUT_CYC   = 255,
    parameter int         RECOV_CYC     = 4
) (
    input  logic                     CLK_32,
    input  logic                     RESET,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic [WB_ADDR_WIDTH-1:0] Adr_slave_i_lbus_reg,
    output logic                     We_slave_i_lbus_reg,
    output logic [WB_DATA_WIDTH-1:0] Dat_slave_io_lbus,
    output logic                     ack_access_str,
    output logic                     ack_access_reg_3,
    input  logic                     ack_set_reg,
    input  logic [WB_DATA_WIDTH-1:0] Dat_slave_o_lbus,
    input  logic [4:0]               MKO_READYD_N,
    output logic                     busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STR,
        S_ACC,
        S_DONE,
        S_RECOV
    } state_t;

    state_t state, state_nx;

    logic [7:0]               cnt;
    logic [7:0]               rcnt;
    logic                     abort_q;
    logic                     ack_q;
    logic                     err_q;
    logic [WB_DATA_WIDTH-1:0] rdat_q;
    logic [4:0]               rdy_meta;
    logic [4:0]               rdy_sync;
    logic [7:0]               rdy_ext;

    logic       req;
    logic       req_unmapped;
    logic [2:0] sel;
    logic       is_int;
    logic       chip_rdy;
    logic       acc_done;
    logic       acc_tmo;

    assign req          = wb_cyc_i & wb_stb_i;
    assign req_unmapped = (wb_adr_i[WB_ADDR_WIDTH-1 -: 2] == 2'b11);
    assign sel          = Adr_slave_i_lbus_reg[WB_ADDR_WIDTH-1 -: 3];
    assign is_int       = (sel == MKO_INT_REG);

    // Codes 5..7 never reach the chip path; pad so the select stays in range.
    assign rdy_ext  = {3'b111, rdy_sync};
    assign chip_rdy = ~rdy_ext[sel];

    assign acc_done = is_int ? ack_set_reg
                             : ((cnt >= 8'(MIN_ACC_CYC - 1)) && chip_rdy);
    assign acc_tmo  = (cnt == 8'(TIMEOUT_CYC));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = req_unmapped ? S_RECOV : S_STR;
            S_STR:   state_nx = S_ACC;
            S_ACC:   if (acc_done || acc_tmo) state_nx = S_DONE;
            S_DONE:  state_nx = S_RECOV;
            S_RECOV: if (rcnt == 8'(RECOV_CYC - 1)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_32) begin
        if (RESET) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            rcnt                 <= '0;
            abort_q              <= 1'b0;
            ack_q                <= 1'b0;
            err_q                <= 1'b0;
            rdat_q               <= '0;
            rdy_meta             <= '1;
            rdy_sync             <= '1;
            Adr_slave_i_lbus_reg <= '0;
            We_slave_i_lbus_reg  <= 1'b0;
            Dat_slave_io_lbus    <= '0;
        end else begin
            state    <= state_nx;
            rdy_meta <= MKO_READYD_N;
            rdy_sync <= rdy_meta;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        Adr_slave_i_lbus_reg <= wb_adr_i;
                        We_slave_i_lbus_reg  <= wb_we_i;
                        Dat_slave_io_lbus    <= wb_dat_i;
                        abort_q              <= 1'b0;
                        rcnt                 <= '0;
                        err_q                <= req_unmapped;
                    end
                end
                S_STR: begin
                    cnt <= '0;
                    if (!wb_cyc_i) abort_q <= 1'b1;
                end
                S_ACC: begin
                    if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                    if (!wb_cyc_i) abort_q <= 1'b1;
                    // A master that walked away still lets the chip cycle finish,
                    // but gets no response for it.
                    if (acc_done) begin
                        rdat_q <= We_slave_i_lbus_reg ? '0 : Dat_slave_o_lbus;
                        ack_q  <= ~(abort_q | ~wb_cyc_i);
                    end else if (acc_tmo) begin
                        err_q  <= ~(abort_q | ~wb_cyc_i);
                    end
                end
                S_DONE: begin
                    rcnt   <= '0;
                    rdat_q <= '0;
                end
                S_RECOV: rcnt <= rcnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign wb_ack_o         = ack_q & wb_cyc_i;
    assign wb_err_o         = err_q & wb_cyc_i;
    assign wb_dat_o         = rdat_q;
    assign ack_access_str   = (state == S_STR);
    assign ack_access_reg_3 = (state == S_STR) || (state == S_ACC) || (state == S_DONE);
    assign busy_o           = (state != S_IDLE);

endmodule

// File: tb/tb_mko_lbus_seq.sv
`timescale 1ns/1ps
// Bench for mko_lbus_seq: fixed vectors, multi-cycle corner sequences and random
// accesses scored against a transaction-level timing/data model.
module tb_mko_lbus_seq;

    localparam int MIN = 8;
    localparam int TMO = 255;
    localparam int REC = 4;

    logic        CLK_32 = 1'b0;
    logic        RESET  = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [15:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [15:0] Adr_slave_i_lbus_reg;
    logic        We_slave_i_lbus_reg;
    logic [15:0] Dat_slave_io_lbus;
    logic        ack_access_str, ack_access_reg_3;
    logic        ack_set_reg = 1'b0;
    logic [15:0] Dat_slave_o_lbus = '0;
    logic [4:0]  MKO_READYD_N = 5'b11111;
    logic        busy_o;

    mko_lbus_seq #(
        .WB_DATA_WIDTH(16), .WB_ADDR_WIDTH(16), .MKO_INT_REG(3'b101),
        .MIN_ACC_CYC(MIN), .TIMEOUT_CYC(TMO), .RECOV_CYC(REC)
    ) dut (
        .CLK_32(CLK_32), .RESET(RESET),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .Adr_slave_i_lbus_reg(Adr_slave_i_lbus_reg),
        .We_slave_i_lbus_reg(We_slave_i_lbus_reg),
        .Dat_slave_io_lbus(Dat_slave_io_lbus),
        .ack_access_str(ack_access_str), .ack_access_reg_3(ack_access_reg_3),
        .ack_set_reg(ack_set_reg), .Dat_slave_o_lbus(Dat_slave_o_lbus),
        .MKO_READYD_N(MKO_READYD_N), .busy_o(busy_o)
    );

    always #16 CLK_32 = ~CLK_32;

    // Stand-in for the MKO block: internal regs 0..4 answer two cycles after the
    // strobe, chips return the inverted address as read data.
    logic [15:0] mko_mem [8];
    logic        p1 = 1'b0, p2 = 1'b0;
    initial for (int i = 0; i < 8; i++) mko_mem[i] = '0;
    always @(negedge CLK_32) begin
        ack_set_reg = p2;
        p2 = p1;
        p1 = ack_access_str && Adr_slave_i_lbus_reg[15:13] == 3'b101 && Adr_slave_i_lbus_reg[2:0] < 3'd5;
        if (p1 && We_slave_i_lbus_reg) mko_mem[Adr_slave_i_lbus_reg[2:0]] = Dat_slave_io_lbus;
        Dat_slave_o_lbus = (Adr_slave_i_lbus_reg[15:13] == 3'b101) ? mko_mem[Adr_slave_i_lbus_reg[2:0]]
                                                                   : ~Adr_slave_i_lbus_reg;
    end

    int checks = 0, errors = 0;
    logic [15:0] ref_mem [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // kind: 1 = ack, 2 = err; lat counted in cycles after the request edge.
    function automatic void model(input logic [15:0] adr, input logic we, input int rdy,
                                  output int kind, output int lat, output logic [15:0] d);
        logic [2:0] rg;
        int t;
        rg = adr[15:13];
        d  = '0;
        if (rg >= 3'd6) begin
            kind = 2; lat = 1;
        end else if (rg == 3'd5) begin
            if (adr[2:0] >= 3'd5) begin
                kind = 2; lat = TMO + 3;
            end else begin
                kind = 1; lat = 4;
                if (!we) d = ref_mem[adr[2:0]];
            end
        end else begin
            t = (MIN > rdy + 2) ? MIN : rdy + 2;
            if (rdy < 0 || t > TMO + 1) begin
                kind = 2; lat = TMO + 3;
            end else begin
                kind = 1; lat = t + 2;
                if (!we) d = ~adr;
            end
        end
    endfunction

    task automatic run_txn(input logic [15:0] adr, input logic we, input logic [15:0] dat, input int rdy,
                           output int kind, output int lat, output logic [15:0] rdat,
                           output int nstr, output int str_at, output bit reg3_ok, output bit latch_ok);
        bit got = 0;
        bit unm = (adr[15:14] == 2'b11);
        int chip = int'(adr[15:13]);
        kind = 0; lat = -1; rdat = '0; nstr = 0; str_at = -1; reg3_ok = 1; latch_ok = 1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
        for (int n = 1; n <= 400 && !got; n++) begin
            @(negedge CLK_32);
            if (ack_access_str) begin
                nstr++;
                if (str_at < 0) str_at = n;
            end
            if (ack_access_reg_3 == unm) reg3_ok = 0;
            if (Adr_slave_i_lbus_reg !== adr || We_slave_i_lbus_reg !== we || Dat_slave_io_lbus !== dat)
                latch_ok = 0;
            if (wb_ack_o || wb_err_o) begin
                kind = (wb_ack_o ? 1 : 0) + (wb_err_o ? 2 : 0);
                lat  = n;
                rdat = wb_dat_o;
                got  = 1;
            end
            if (rdy >= 0 && n == 1 + rdy && chip < 5) MKO_READYD_N[chip] = 1'b0;
        end
        if (!got) chk("txn_response_timeout", 0, 1);
        wb_cyc_i = 0; wb_stb_i = 0; MKO_READYD_N = 5'b11111;
    endtask

    task automatic chk_recov(input bit unm);
        bit ok = 1;
        int ncyc = unm ? REC - 1 : REC;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK_32);
            if (!busy_o || ack_access_reg_3 || ack_access_str || wb_ack_o || wb_err_o || wb_dat_o != 0) ok = 0;
        end
        chk("recov_window", 32'(ok), 1);
        @(negedge CLK_32);
        chk("idle_after_recov", 32'(busy_o), 0);
    endtask

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [15:0] dat;
        int          rdy;
        int          kind;
        int          lat;
        logic [15:0] rdat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int kind, lat, nstr, str_at, ek, el;
        logic [15:0] rdat, ed, adr;
        bit r3, lok, unm, seen;
        int m;

        vecs[0]  = '{16'hA001, 1'b1, 16'h8015, -1, 1, 4,   16'h0000};
        vecs[1]  = '{16'hA001, 1'b0, 16'h0000, -1, 1, 4,   16'h8015};
        vecs[2]  = '{16'h4000, 1'b1, 16'h1234,  3, 1, 10,  16'h0000};
        vecs[3]  = '{16'h4000, 1'b0, 16'h0000,  3, 1, 10,  16'hBFFF};
        vecs[4]  = '{16'hE000, 1'b0, 16'h0000, -1, 2, 1,   16'h0000};
        vecs[5]  = '{16'hC123, 1'b1, 16'h5555, -1, 2, 1,   16'h0000};
        vecs[6]  = '{16'h2000, 1'b0, 16'h0000, 10, 1, 14,  16'hDFFF};
        vecs[7]  = '{16'hA007, 1'b0, 16'h0000, -1, 2, 258, 16'h0000};
        vecs[8]  = '{16'h0000, 1'b1, 16'hCAFE,  0, 1, 10,  16'h0000};
        vecs[9]  = '{16'hA004, 1'b1, 16'h00FF, -1, 1, 4,   16'h0000};
        vecs[10] = '{16'hA004, 1'b0, 16'h0000, -1, 1, 4,   16'h00FF};
        vecs[11] = '{16'h8000, 1'b0, 16'h0000, -1, 2, 258, 16'h0000};
        for (int i = 0; i < 5; i++) ref_mem[i] = '0;

        repeat (3) @(negedge CLK_32);
        chk("reset_outputs", {busy_o, wb_ack_o, wb_err_o, ack_access_str, ack_access_reg_3,
                              We_slave_i_lbus_reg, 26'(wb_dat_o | Adr_slave_i_lbus_reg | Dat_slave_io_lbus)}, 0);
        RESET = 0;
        @(negedge CLK_32);
        chk("idle_after_reset", 32'(busy_o), 0);

        for (int i = 0; i < 12; i++) begin
            unm = (vecs[i].adr[15:14] == 2'b11);
            run_txn(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].rdy, kind, lat, rdat, nstr, str_at, r3, lok);
            chk($sformatf("vec%0d_kind", i), kind, vecs[i].kind);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_rdata", i), 32'(rdat), 32'(vecs[i].rdat));
            chk($sformatf("vec%0d_str_count", i), nstr, unm ? 0 : 1);
            if (!unm) chk($sformatf("vec%0d_str_cycle", i), str_at, 1);
            chk($sformatf("vec%0d_reg3_window", i), 32'(r3), 1);
            chk($sformatf("vec%0d_latched", i), 32'(lok), 1);
            chk_recov(unm);
        end
        ref_mem[1] = 16'h8015;
        ref_mem[4] = 16'h00FF;

        // Back-to-back: a request left pending through RECOV is taken on the first IDLE edge.
        wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 16'hA003; wb_we_i = 1; wb_dat_i = 16'h0055;
        seen = 0; m = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge CLK_32);
            if (wb_ack_o) begin seen = 1; m = n; end
        end
        chk("b2b_first_ack_cycle", m, 4);
        wb_we_i = 0;
        seen = 0; m = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge CLK_32);
            if (ack_access_str) begin seen = 1; m = n; end
        end
        chk("b2b_second_str_cycle", m, REC + 2);
        seen = 0; m = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge CLK_32);
            if (wb_ack_o) begin seen = 1; m = n; rdat = wb_dat_o; end
        end
        chk("b2b_second_ack_cycle", m, 3);
        chk("b2b_read_data", 32'(rdat), 32'h0055);
        wb_cyc_i = 0; wb_stb_i = 0;
        ref_mem[3] = 16'h0055;
        chk_recov(0);

        // Master drops cyc during ACC: no response, back to IDLE after RECOV.
        wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 16'hA002; wb_we_i = 0;
        seen = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK_32);
            if (wb_ack_o || wb_err_o) seen = 1;
            if (n == 2) begin wb_cyc_i = 0; wb_stb_i = 0; end
            if (n == 8) chk("abort_busy_in_recov", 32'(busy_o), 1);
            if (n == 9) chk("abort_idle", 32'(busy_o), 0);
        end
        chk("abort_no_response", 32'(seen), 0);

        // Synchronous reset in the middle of ACC.
        wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 16'hA001; wb_we_i = 0;
        repeat (2) @(negedge CLK_32);
        chk("pre_reset_in_acc", {ack_access_reg_3, ack_access_str}, 2'b10);
        RESET = 1;
        @(negedge CLK_32);
        chk("mid_reset_outputs", {busy_o, wb_ack_o, wb_err_o, ack_access_str, ack_access_reg_3,
                                  We_slave_i_lbus_reg, 26'(wb_dat_o | Adr_slave_i_lbus_reg | Dat_slave_io_lbus)}, 0);
        RESET = 0; wb_cyc_i = 0; wb_stb_i = 0;
        repeat (4) @(negedge CLK_32);
        chk("post_reset_idle", {busy_o, wb_ack_o, wb_err_o}, 0);

        // Random accesses scored against the transaction model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] rg;
            logic       we;
            logic [15:0] dat;
            int         rdy, r;
            r  = int'($urandom_range(0, 9));
            rg = (r < 5) ? 3'(r) : (r < 8) ? 3'd5 : (r == 8) ? 3'd6 : 3'd7;
            adr = {rg, 13'($urandom)};
            if (rg == 3'd5)
                adr[2:0] = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            we  = 1'($urandom_range(0, 1));
            dat = 16'($urandom);
            rdy = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 14));
            model(adr, we, rdy, ek, el, ed);
            unm = (rg >= 3'd6);
            run_txn(adr, we, dat, rdy, kind, lat, rdat, nstr, str_at, r3, lok);
            chk($sformatf("rnd%0d_kind adr=%h", i, adr), kind, ek);
            chk($sformatf("rnd%0d_latency adr=%h", i, adr), lat, el);
            chk($sformatf("rnd%0d_rdata adr=%h", i, adr), 32'(rdat), 32'(ed));
            chk($sformatf("rnd%0d_reg3", i), 32'(r3), 1);
            if (ek == 1 && we && rg == 3'd5) ref_mem[adr[2:0]] = dat;
            chk_recov(unm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
